// File: rtl/hc_secded_dec.sv
// hc_secded_dec -- pipelined Hamming SECDED decoder with error counters.
//
// The codeword has positions 0..N (N = DATA_WD + CHK_WD). Position 0 is the
// overall parity bit. Check bits sit at the power-of-two positions. Data bits
// fill the remaining positions, LSB first, in ascending order.
//
// The decoder has two register stages. Stage 1 holds the syndrome, the
// overall parity, the raw codeword and the captured correction enable.
// Stage 2 holds the corrected payload and its classification.
//
// Ports
//   i_clk, i_rst_n        clock; asynchronous active-low reset
//   i_valid / o_ready     input handshake (o_ready = !o_valid || i_ready)
//   i_enc_data            SECDED codeword [DATA_WD+CHK_WD:0]
//   i_corr_en             1 = correct single errors, 0 = detect only
//   i_cnt_clr             synchronous clear of both error counters
//   o_valid / i_ready     output handshake
//   o_dec_data            decoded payload [DATA_WD:1]
//   o_err_flag            any error detected
//   o_err_type            00 none, 01 single, 10 uncorrectable, 11 parity-bit single
//   o_syndrome            Hamming syndrome [CHK_WD:1]
//   o_sec_cnt, o_ded_cnt  saturating counts of delivered single / uncorrectable errors
module hc_secded_dec #(
  parameter int DATA_WD = 8,
  parameter int CHK_WD  = 4,
  parameter int CNT_WD  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_WD+CHK_WD:0]   i_enc_data,
  input  logic                      i_corr_en,
  input  logic                      i_cnt_clr,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_WD:1]          o_dec_data,
  output logic                      o_err_flag,
  output logic [1:0]                o_err_type,
  output logic [CHK_WD:1]           o_syndrome,
  output logic [CNT_WD-1:0]         o_sec_cnt,
  output logic [CNT_WD-1:0]         o_ded_cnt
);

  localparam int N = DATA_WD + CHK_WD;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SINGLE = 2'b01;
  localparam logic [1:0] ERR_DOUBLE = 2'b10;
  localparam logic [1:0] ERR_PARITY = 2'b11;

  generate
    if ((2 ** CHK_WD) < (N + 1)) begin : g_bad_params
      $error("hc_secded_dec: CHK_WD too small to address DATA_WD+CHK_WD positions");
    end
  endgenerate

  // XOR of the indices of every set position 1..N.
  function automatic logic [CHK_WD-1:0] calc_syn(input logic [N:0] cw);
    logic [CHK_WD-1:0] s;
    s = '0;
    for (int i = 1; i <= N; i++) begin
      if (cw[i]) s = s ^ CHK_WD'(i);
    end
    return s;
  endfunction

  function automatic logic [1:0] classify(input logic [CHK_WD-1:0] syn, input logic par);
    if (syn == '0)
      return par ? ERR_PARITY : ERR_NONE;
    else if (par && (int'(syn) <= N))
      return ERR_SINGLE;
    else
      return ERR_DOUBLE;
  endfunction

  function automatic logic [N:0] flip_pos(input logic [N:0] cw, input logic [CHK_WD-1:0] syn);
    logic [N:0] r;
    r = cw;
    for (int i = 1; i <= N; i++) begin
      if (CHK_WD'(i) == syn) r[i] = ~cw[i];
    end
    return r;
  endfunction

  // Gather the non-power-of-two positions into the payload, LSB first.
  function automatic logic [DATA_WD-1:0] extract_data(input logic [N:0] cw);
    logic [DATA_WD-1:0] d;
    int                 j;
    d = '0;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  logic              en;
  logic              vld_p1;
  logic [CHK_WD-1:0] syn_p1;
  logic              par_p1;
  logic [N:0]        cw_p1;
  logic              corr_p1;
  logic [1:0]        type_p1;
  logic [N:0]        fix_cw_p1;
  logic              fire;
  logic              sec_inc;
  logic              ded_inc;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // ---- stage 1: syndrome, overall parity, raw codeword, correction enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      syn_p1  <= '0;
      par_p1  <= 1'b0;
      cw_p1   <= '0;
      corr_p1 <= 1'b0;
    end else if (en) begin
      vld_p1  <= i_valid;
      syn_p1  <= calc_syn(i_enc_data);
      par_p1  <= ^i_enc_data;
      cw_p1   <= i_enc_data;
      corr_p1 <= i_corr_en;
    end
  end

  always_comb begin
    type_p1   = classify(syn_p1, par_p1);
    fix_cw_p1 = cw_p1;
    if ((type_p1 == ERR_SINGLE) && corr_p1) fix_cw_p1 = flip_pos(cw_p1, syn_p1);
  end

  // ---- stage 2: corrected payload and classification
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_dec_data <= '0;
      o_err_type <= ERR_NONE;
      o_err_flag <= 1'b0;
      o_syndrome <= '0;
    end else if (en) begin
      o_valid    <= vld_p1;
      o_dec_data <= extract_data(fix_cw_p1);
      o_err_type <= type_p1;
      o_err_flag <= (type_p1 != ERR_NONE);
      o_syndrome <= syn_p1;
    end
  end

  // ---- counters: only results actually handed downstream are counted
  assign fire    = o_valid && i_ready;
  assign sec_inc = fire && ((o_err_type == ERR_SINGLE) || (o_err_type == ERR_PARITY));
  assign ded_inc = fire && (o_err_type == ERR_DOUBLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sec_cnt <= '0;
      o_ded_cnt <= '0;
    end else begin
      if (i_cnt_clr)                         o_sec_cnt <= '0;
      else if (sec_inc && (o_sec_cnt != '1)) o_sec_cnt <= o_sec_cnt + 1'b1;
      if (i_cnt_clr)                         o_ded_cnt <= '0;
      else if (ded_inc && (o_ded_cnt != '1)) o_ded_cnt <= o_ded_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hc_secded_dec.sv
// Testbench for hc_secded_dec (DATA_WD=8, CHK_WD=4). A second instance with
// CNT_WD=2 shares all inputs and is used for counter saturation.
module tb_hc_secded_dec;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int NB = 12;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          i_corr_en;
  logic          i_cnt_clr;
  logic          i_ready;
  logic [NB:0]   i_enc_data;

  logic          o_ready, o_valid, o_err_flag;
  logic [DW:1]   o_dec_data;
  logic [1:0]    o_err_type;
  logic [CW:1]   o_syndrome;
  logic [15:0]   o_sec_cnt, o_ded_cnt;

  logic          c2_ready, c2_valid, c2_err_flag;
  logic [DW:1]   c2_dec_data;
  logic [1:0]    c2_err_type;
  logic [CW:1]   c2_syndrome;
  logic [1:0]    c2_sec_cnt, c2_ded_cnt;

  hc_secded_dec #(.DATA_WD(DW), .CHK_WD(CW), .CNT_WD(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_enc_data(i_enc_data), .i_corr_en(i_corr_en), .i_cnt_clr(i_cnt_clr),
    .o_valid(o_valid), .i_ready(i_ready), .o_dec_data(o_dec_data),
    .o_err_flag(o_err_flag), .o_err_type(o_err_type), .o_syndrome(o_syndrome),
    .o_sec_cnt(o_sec_cnt), .o_ded_cnt(o_ded_cnt));

  hc_secded_dec #(.DATA_WD(DW), .CHK_WD(CW), .CNT_WD(2)) dut_c2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(c2_ready),
    .i_enc_data(i_enc_data), .i_corr_en(i_corr_en), .i_cnt_clr(i_cnt_clr),
    .o_valid(c2_valid), .i_ready(i_ready), .o_dec_data(c2_dec_data),
    .o_err_flag(c2_err_flag), .o_err_type(c2_err_type), .o_syndrome(c2_syndrome),
    .o_sec_cnt(c2_sec_cnt), .o_ded_cnt(c2_ded_cnt));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] etype;
    logic [3:0] syn;
  } res_t;

  int chk_total = 0;
  int chk_pass  = 0;
  int exp_sec   = 0;
  int exp_ded   = 0;

  // Build a codeword from the layout rules: data into non-power-of-two slots,
  // each check bit covering the positions whose index has its bit set.
  function automatic logic [NB:0] encode(input logic [DW-1:0] d);
    logic [NB:0] cw;
    int k;
    int par;
    cw = '0;
    k = 0;
    for (int p = 1; p <= NB; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < CW; b++) begin
      par = 0;
      for (int p = 1; p <= NB; p++)
        if (((p >> b) & 1) == 1 && p != (1 << b) && cw[p]) par = par ^ 1;
      cw[1 << b] = (par == 1);
    end
    cw[0] = ^cw[NB:1];
    return cw;
  endfunction

  function automatic res_t model(input logic [NB:0] cw, input logic corr);
    res_t r;
    int syn;
    int par;
    int k;
    logic [NB:0] c;
    syn = 0;
    par = 0;
    c = cw;
    for (int p = 0; p <= NB; p++)
      if (cw[p]) begin
        syn = syn ^ p;
        par = par ^ 1;
      end
    if (syn == 0 && par == 0)      r.etype = 2'd0;
    else if (syn == 0)             r.etype = 2'd3;
    else if (par == 1 && syn <= NB) begin
      r.etype = 2'd1;
      if (corr) c[syn] = ~c[syn];
    end else                       r.etype = 2'd2;
    r.syn = syn[3:0];
    r.data = '0;
    k = 0;
    for (int p = 1; p <= NB; p++)
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        r.data[k] = c[p];
        k++;
      end
    return r;
  endfunction

  // Stimulus only: present one word with i_ready=1, return o_valid seen after
  // the acceptance edge, and leave time just after the result edge.
  task automatic drive_word(input logic [NB:0] cw, input logic corr, output logic mid_vld);
    i_valid = 1'b1; i_enc_data = cw; i_corr_en = corr; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    mid_vld = o_valid;
    @(posedge i_clk); #1;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_corr_en = 1'b0; i_cnt_clr = 1'b0;
    i_ready = 1'b1; i_enc_data = '0;
    @(posedge i_clk); @(posedge i_clk); #1;
    chk_total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", o_valid); else chk_pass++;
    chk_total++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", o_ready); else chk_pass++;
    chk_total++;
    if (o_dec_data !== 8'h00 || o_err_type !== 2'b00 || o_err_flag !== 1'b0 || o_syndrome !== 4'h0)
      $display("FAIL rst_outputs got data %h type %b flag %b syn %h exp all 0",
               o_dec_data, o_err_type, o_err_flag, o_syndrome);
    else chk_pass++;
    chk_total++;
    if (o_sec_cnt !== 16'd0 || o_ded_cnt !== 16'd0)
      $display("FAIL rst_cnt got sec %0d ded %0d exp 0 0", o_sec_cnt, o_ded_cnt);
    else chk_pass++;
    @(negedge i_clk); i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean();
    logic mid;
    drive_word(encode(8'hA5), 1'b1, mid);
    chk_total++; if (mid !== 1'b0) $display("FAIL clean_latency_early got o_valid %b exp 0", mid); else chk_pass++;
    chk_total++; if (o_valid !== 1'b1) $display("FAIL clean_valid got %b exp 1", o_valid); else chk_pass++;
    chk_total++; if (o_dec_data !== 8'hA5) $display("FAIL clean_data got %h exp a5", o_dec_data); else chk_pass++;
    chk_total++;
    if (o_err_type !== 2'b00 || o_err_flag !== 1'b0 || o_syndrome !== 4'd0)
      $display("FAIL clean_class got type %b flag %b syn %0d exp 00 0 0", o_err_type, o_err_flag, o_syndrome);
    else chk_pass++;
    tick();
    chk_total++;
    if (o_sec_cnt !== 16'(exp_sec) || o_ded_cnt !== 16'(exp_ded))
      $display("FAIL clean_cnt got sec %0d ded %0d exp %0d %0d", o_sec_cnt, o_ded_cnt, exp_sec, exp_ded);
    else chk_pass++;
  endtask

  task automatic test_single();
    logic mid;
    logic [NB:0] one;
    logic [NB:0] cw;
    res_t e;
    one = 1;
    cw = encode(8'hA5) ^ (one << 5);
    drive_word(cw, 1'b1, mid);
    chk_total++; if (o_dec_data !== 8'hA5) $display("FAIL sec_corr_data got %h exp a5", o_dec_data); else chk_pass++;
    chk_total++;
    if (o_err_type !== 2'b01 || o_err_flag !== 1'b1 || o_syndrome !== 4'd5)
      $display("FAIL sec_corr_class got type %b flag %b syn %0d exp 01 1 5", o_err_type, o_err_flag, o_syndrome);
    else chk_pass++;
    tick(); exp_sec++;
    chk_total++; if (o_sec_cnt !== 16'(exp_sec)) $display("FAIL sec_cnt got %0d exp %0d", o_sec_cnt, exp_sec); else chk_pass++;

    e = model(cw, 1'b0);
    drive_word(cw, 1'b0, mid);
    chk_total++;
    if (o_dec_data !== e.data || o_dec_data === 8'hA5)
      $display("FAIL sec_detect_data got %h exp %h (raw)", o_dec_data, e.data);
    else chk_pass++;
    chk_total++; if (o_err_type !== 2'b01) $display("FAIL sec_detect_type got %b exp 01", o_err_type); else chk_pass++;
    tick(); exp_sec++;
    chk_total++; if (o_sec_cnt !== 16'(exp_sec)) $display("FAIL sec_detect_cnt got %0d exp %0d", o_sec_cnt, exp_sec); else chk_pass++;
  endtask

  task automatic test_parity_double();
    logic mid;
    logic [NB:0] one;
    logic [NB:0] cw;
    res_t e;
    one = 1;
    drive_word(encode(8'hA5) ^ one, 1'b1, mid);
    chk_total++;
    if (o_err_type !== 2'b11 || o_dec_data !== 8'hA5 || o_syndrome !== 4'd0 || o_err_flag !== 1'b1)
      $display("FAIL par_class got type %b data %h syn %0d flag %b exp 11 a5 0 1",
               o_err_type, o_dec_data, o_syndrome, o_err_flag);
    else chk_pass++;
    tick(); exp_sec++;
    chk_total++; if (o_sec_cnt !== 16'(exp_sec)) $display("FAIL par_cnt got %0d exp %0d", o_sec_cnt, exp_sec); else chk_pass++;

    cw = encode(8'hA5) ^ (one << 3) ^ (one << 6);
    e = model(cw, 1'b1);
    drive_word(cw, 1'b1, mid);
    chk_total++;
    if (o_err_type !== 2'b10 || o_syndrome !== 4'd5 || o_err_flag !== 1'b1)
      $display("FAIL ded_class got type %b syn %0d flag %b exp 10 5 1", o_err_type, o_syndrome, o_err_flag);
    else chk_pass++;
    chk_total++; if (o_dec_data !== e.data) $display("FAIL ded_data got %h exp %h", o_dec_data, e.data); else chk_pass++;
    tick(); exp_ded++;
    chk_total++;
    if (o_ded_cnt !== 16'(exp_ded) || o_sec_cnt !== 16'(exp_sec))
      $display("FAIL ded_cnt got ded %0d sec %0d exp %0d %0d", o_ded_cnt, o_sec_cnt, exp_ded, exp_sec);
    else chk_pass++;
  endtask

  task automatic test_back_to_back();
    res_t exp_q[$];
    res_t e;
    int sent, got, cyc, nf, p1, p2;
    logic held;
    logic [7:0] hd;
    logic [1:0] ht;
    logic [3:0] hs;
    logic [NB:0] cur_cw;
    logic [NB:0] one;
    logic cur_corr;
    one = 1; sent = 0; got = 0; cyc = 0; held = 1'b0;
    hd = '0; ht = '0; hs = '0;
    cur_cw = encode(8'h00); cur_corr = 1'b1;
    while (got < 256 && cyc < 4000) begin
      i_valid = (sent < 256);
      i_enc_data = cur_cw;
      i_corr_en = cur_corr;
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      if (held) begin
        chk_total++;
        if (o_valid !== 1'b1 || o_dec_data !== hd || o_err_type !== ht || o_syndrome !== hs)
          $display("FAIL b2b_stall_hold got v %b data %h type %b syn %0d exp 1 %h %b %0d",
                   o_valid, o_dec_data, o_err_type, o_syndrome, hd, ht, hs);
        else chk_pass++;
      end
      if (o_valid && i_ready) begin
        chk_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra got result %h exp none", o_dec_data);
        else begin
          e = exp_q.pop_front();
          if (o_dec_data !== e.data || o_err_type !== e.etype || o_syndrome !== e.syn ||
              o_err_flag !== (e.etype != 2'b00))
            $display("FAIL b2b_result #%0d got data %h type %b syn %0d flag %b exp %h %b %0d",
                     got, o_dec_data, o_err_type, o_syndrome, o_err_flag, e.data, e.etype, e.syn);
          else chk_pass++;
          if (e.etype == 2'b01 || e.etype == 2'b11) exp_sec++;
          if (e.etype == 2'b10) exp_ded++;
        end
        got++;
        held = 1'b0;
      end else if (o_valid) begin
        held = 1'b1; hd = o_dec_data; ht = o_err_type; hs = o_syndrome;
      end else held = 1'b0;
      if (i_valid && o_ready) begin
        exp_q.push_back(model(cur_cw, cur_corr));
        sent++;
        cur_cw = encode(8'(sent));
        cur_corr = ($urandom_range(0, 1) == 1);
        nf = $urandom_range(0, 3);
        p1 = $urandom_range(0, NB);
        p2 = (p1 + 1 + $urandom_range(0, NB - 1)) % (NB + 1);
        if (nf == 1) cur_cw = cur_cw ^ (one << p1);
        if (nf == 2) cur_cw = cur_cw ^ (one << p1) ^ (one << p2);
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk_total++;
    if (got != 256 || exp_q.size() != 0)
      $display("FAIL b2b_count got %0d delivered (%0d pending) exp 256 0", got, exp_q.size());
    else chk_pass++;
    chk_total++;
    if (o_sec_cnt !== 16'(exp_sec) || o_ded_cnt !== 16'(exp_ded))
      $display("FAIL b2b_cnt got sec %0d ded %0d exp %0d %0d", o_sec_cnt, o_ded_cnt, exp_sec, exp_ded);
    else chk_pass++;
  endtask

  task automatic test_saturation();
    logic mid;
    logic [NB:0] one;
    one = 1;
    i_cnt_clr = 1'b1; tick(); i_cnt_clr = 1'b0;
    exp_sec = 0; exp_ded = 0;
    chk_total++;
    if (c2_sec_cnt !== 2'd0 || o_sec_cnt !== 16'd0 || o_ded_cnt !== 16'd0)
      $display("FAIL clr_cnt got c2 %0d sec %0d ded %0d exp 0 0 0", c2_sec_cnt, o_sec_cnt, o_ded_cnt);
    else chk_pass++;
    for (int n = 0; n < 5; n++) begin
      drive_word(encode(8'($urandom)) ^ (one << $urandom_range(1, NB)), 1'($urandom_range(0, 1)), mid);
      tick(); exp_sec++;
    end
    chk_total++; if (c2_sec_cnt !== 2'd3) $display("FAIL sat_c2 got %0d exp 3", c2_sec_cnt); else chk_pass++;
    chk_total++; if (o_sec_cnt !== 16'(exp_sec)) $display("FAIL sat_wide got %0d exp %0d", o_sec_cnt, exp_sec); else chk_pass++;
    drive_word(encode(8'h5A) ^ (one << 7), 1'b1, mid);
    i_cnt_clr = 1'b1; tick(); i_cnt_clr = 1'b0;
    exp_sec = 0;
    chk_total++;
    if (c2_sec_cnt !== 2'd0 || o_sec_cnt !== 16'd0)
      $display("FAIL clr_vs_inc got c2 %0d sec %0d exp 0 0", c2_sec_cnt, o_sec_cnt);
    else chk_pass++;
  endtask

  task automatic test_reset_midflight();
    logic mid;
    logic [NB:0] one;
    int seen;
    one = 1;
    drive_word(encode(8'h11) ^ (one << 9), 1'b1, mid);
    tick(); exp_sec++;
    chk_total++; if (o_sec_cnt !== 16'(exp_sec)) $display("FAIL pre_rst_cnt got %0d exp %0d", o_sec_cnt, exp_sec); else chk_pass++;
    i_ready = 1'b0;
    i_valid = 1'b1; i_enc_data = encode(8'h22) ^ (one << 3); i_corr_en = 1'b1;
    @(posedge i_clk); #1;
    i_enc_data = encode(8'h33) ^ (one << 3) ^ (one << 10);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk_total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_dec_data !== 8'h00 || o_err_type !== 2'b00)
      $display("FAIL rst_async got v %b rdy %b data %h type %b exp 0 1 00 00", o_valid, o_ready, o_dec_data, o_err_type);
    else chk_pass++;
    chk_total++;
    if (o_sec_cnt !== 16'd0 || o_ded_cnt !== 16'd0 || c2_sec_cnt !== 2'd0)
      $display("FAIL rst_async_cnt got sec %0d ded %0d c2 %0d exp 0 0 0", o_sec_cnt, o_ded_cnt, c2_sec_cnt);
    else chk_pass++;
    exp_sec = 0; exp_ded = 0;
    @(negedge i_clk); i_rst_n = 1'b1; i_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) seen++;
    end
    chk_total++; if (seen != 0) $display("FAIL rst_stale got %0d valid cycles exp 0", seen); else chk_pass++;
    @(posedge i_clk); #1;
    drive_word(encode(8'h3C), 1'b0, mid);
    chk_total++;
    if (mid !== 1'b0 || o_valid !== 1'b1 || o_dec_data !== 8'h3C || o_err_type !== 2'b00)
      $display("FAIL post_rst_first got mid %b v %b data %h type %b exp 0 1 3c 00", mid, o_valid, o_dec_data, o_err_type);
    else chk_pass++;
    tick();
    chk_total++;
    if (o_sec_cnt !== 16'd0 || o_ded_cnt !== 16'd0)
      $display("FAIL post_rst_cnt got sec %0d ded %0d exp 0 0", o_sec_cnt, o_ded_cnt);
    else chk_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_parity_double();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
